// File: rtl/psum_output_collector.sv
// ---------------------------------------------------------------------------
// psum_output_collector
//
// Realigns per-kernel partial sums coming out of the line convolution engine.
// Each kernel lane may become valid on a different cycle, so every lane owns
// a small circular FIFO. A complete multi-kernel word is presented
// (first-word-fall-through) only when every lane holds at least one entry.
// All lanes are popped together when downstream accepts the word.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   i_psum         packed lane psums, lane k = [BIT_WIDTH*(k+1)-1 : BIT_WIDTH*k]
//   i_psum_val     per-lane valid qualifiers
//   o_data         aligned word (same lane packing), 0 when o_data_val=0
//   o_data_val     every lane FIFO is non-empty
//   i_data_ready   downstream accepts o_data this cycle
//   o_almost_full  some lane holds FIFO_DEPTH-2 or more entries
//   o_lane_count   per-lane occupancy, packed like i_psum
//   err_overflow   saturating count of lane writes dropped on a full FIFO
// ---------------------------------------------------------------------------
module psum_output_collector #(
   parameter int BIT_WIDTH  = 8,
   parameter int NUM_KERNEL = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int REG_WIDTH  = 32
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [BIT_WIDTH*NUM_KERNEL-1:0]             i_psum,
   input  logic [NUM_KERNEL-1:0]                       i_psum_val,
   output logic [BIT_WIDTH*NUM_KERNEL-1:0]             o_data,
   output logic                                        o_data_val,
   input  logic                                        i_data_ready,
   output logic                                        o_almost_full,
   output logic [NUM_KERNEL*$clog2(FIFO_DEPTH+1)-1:0]  o_lane_count,
   output logic [REG_WIDTH-1:0]                        err_overflow
);

   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int DCW = $clog2(NUM_KERNEL + 1);

   localparam logic [CW-1:0] FULL_COUNT   = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] ALMOST_COUNT = CW'(FIFO_DEPTH - 2);

   logic [BIT_WIDTH-1:0] mem        [NUM_KERNEL][FIFO_DEPTH];
   logic [PW-1:0]        wptr       [NUM_KERNEL];
   logic [PW-1:0]        rptr       [NUM_KERNEL];
   logic [CW-1:0]        count      [NUM_KERNEL];
   logic [CW-1:0]        count_next [NUM_KERNEL];

   logic [NUM_KERNEL-1:0] lane_nonempty;
   logic [NUM_KERNEL-1:0] push_ok;
   logic [NUM_KERNEL-1:0] drop;
   logic [DCW-1:0]        drop_count;
   logic [REG_WIDTH:0]    err_sum;
   logic [REG_WIDTH-1:0]  err_next;
   logic                  pop;

   // A word exists only when every lane has something; pops are all-or-nothing
   // so they can only happen while that holds.
   always_comb begin
      lane_nonempty = '0;
      for (int k = 0; k < NUM_KERNEL; k++) begin
         lane_nonempty[k] = (count[k] != '0);
      end
   end

   assign o_data_val = &lane_nonempty;
   assign pop        = o_data_val & i_data_ready;

   // Per-lane push acceptance, overflow detection and occupancy update.
   // A full lane still accepts a push when the same cycle pops, because the
   // slot being written is the one being freed.
   always_comb begin
      push_ok       = '0;
      drop          = '0;
      drop_count    = '0;
      o_almost_full = 1'b0;
      o_data        = '0;
      o_lane_count  = '0;
      for (int k = 0; k < NUM_KERNEL; k++) begin
         count_next[k] = count[k];
         push_ok[k]    = i_psum_val[k] & ((count[k] != FULL_COUNT) | pop);
         drop[k]       = i_psum_val[k] & (count[k] == FULL_COUNT) & ~pop;
         drop_count    = drop_count + DCW'(drop[k]);
         case ({push_ok[k], pop})
            2'b10:   count_next[k] = count[k] + CW'(1);
            2'b01:   count_next[k] = count[k] - CW'(1);
            default: count_next[k] = count[k];
         endcase
         if (count[k] >= ALMOST_COUNT) begin
            o_almost_full = 1'b1;
         end
         if (o_data_val) begin
            o_data[k*BIT_WIDTH +: BIT_WIDTH] = mem[k][rptr[k]];
         end
         o_lane_count[k*CW +: CW] = count[k];
      end
   end

   // Saturating overflow counter: add the number of lanes dropped this cycle,
   // clamping to all-ones on carry out.
   always_comb begin
      err_sum  = {1'b0, err_overflow} + (REG_WIDTH+1)'(drop_count);
      err_next = err_sum[REG_WIDTH] ? '1 : err_sum[REG_WIDTH-1:0];
   end

   // Pointer, count and error counter state. Reset discards everything that
   // is buffered and ignores any push/pop presented alongside it.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_KERNEL; k++) begin
            wptr[k]  <= '0;
            rptr[k]  <= '0;
            count[k] <= '0;
         end
         err_overflow <= '0;
      end else begin
         for (int k = 0; k < NUM_KERNEL; k++) begin
            if (push_ok[k]) begin
               wptr[k] <= wptr[k] + PW'(1);
            end
            if (pop) begin
               rptr[k] <= rptr[k] + PW'(1);
            end
            count[k] <= count_next[k];
         end
         err_overflow <= err_next;
      end
   end

   // Lane storage is deliberately not reset; stale contents are unreachable
   // once the counts are cleared.
   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_KERNEL; k++) begin
         if (!rst && push_ok[k]) begin
            mem[k][wptr[k]] <= i_psum[k*BIT_WIDTH +: BIT_WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_psum_output_collector.sv
// ---------------------------------------------------------------------------
// tb_psum_output_collector
//
// Directed bench for psum_output_collector with default parameters
// (8-bit psums, 4 lanes, 8-deep lane FIFOs, 32-bit error counter).
// Inputs are driven 1 time unit after each rising edge; outputs are checked
// at the same point, after the edge has settled.
// ---------------------------------------------------------------------------
module tb_psum_output_collector;

   localparam int BIT_WIDTH  = 8;
   localparam int NUM_KERNEL = 4;
   localparam int FIFO_DEPTH = 8;
   localparam int REG_WIDTH  = 32;

   logic        clk;
   logic        rst;
   logic [31:0] i_psum;
   logic [3:0]  i_psum_val;
   logic [31:0] o_data;
   logic        o_data_val;
   logic        i_data_ready;
   logic        o_almost_full;
   logic [15:0] o_lane_count;
   logic [31:0] err_overflow;

   int checks;
   int errors;

   psum_output_collector #(
      .BIT_WIDTH  (BIT_WIDTH),
      .NUM_KERNEL (NUM_KERNEL),
      .FIFO_DEPTH (FIFO_DEPTH),
      .REG_WIDTH  (REG_WIDTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_psum        (i_psum),
      .i_psum_val    (i_psum_val),
      .o_data        (o_data),
      .o_data_val    (o_data_val),
      .i_data_ready  (i_data_ready),
      .o_almost_full (o_almost_full),
      .o_lane_count  (o_lane_count),
      .err_overflow  (err_overflow)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Distinct per-lane bytes for word i: lane k byte = 0x10*(k+1) + i.
   function automatic logic [31:0] word_of(input int i);
      return {8'(i + 8'h40), 8'(i + 8'h30), 8'(i + 8'h20), 8'(i + 8'h10)};
   endfunction

   // Advance one rising edge and settle just past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one set of inputs, then take one edge.
   task automatic applyStimulus(input logic [31:0] psum, input logic [3:0] val,
                                input logic ready);
      i_psum       = psum;
      i_psum_val   = val;
      i_data_ready = ready;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      applyStimulus(32'h0, 4'h0, 1'b0);
      rst = 1'b0;
      checks++;
      if (o_data_val !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_val: got %b expected 0", o_data_val);
      end
      checks++;
      if (o_data !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_data: got %h expected 00000000", o_data);
      end
      checks++;
      if (o_almost_full !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_almost_full: got %b expected 0", o_almost_full);
      end
      checks++;
      if (o_lane_count !== 16'h0) begin
         errors++;
         $display("[TB] FAIL reset_lane_count: got %h expected 0000", o_lane_count);
      end
      checks++;
      if (err_overflow !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_err: got %0d expected 0", err_overflow);
      end
   endtask

   task automatic test_aligned();
      applyStimulus(32'h04030201, 4'hF, 1'b1);
      checks++;
      if (o_data_val !== 1'b1 || o_data !== 32'h04030201) begin
         errors++;
         $display("[TB] FAIL aligned_first: got val=%b data=%h expected val=1 data=04030201",
                  o_data_val, o_data);
      end
      applyStimulus(32'h08070605, 4'hF, 1'b1);
      checks++;
      if (o_data_val !== 1'b1 || o_data !== 32'h08070605) begin
         errors++;
         $display("[TB] FAIL aligned_second: got val=%b data=%h expected val=1 data=08070605",
                  o_data_val, o_data);
      end
      applyStimulus(32'h0, 4'h0, 1'b1);
      checks++;
      if (o_data_val !== 1'b0 || o_data !== 32'h0) begin
         errors++;
         $display("[TB] FAIL aligned_empty: got val=%b data=%h expected val=0 data=00000000",
                  o_data_val, o_data);
      end
   endtask

   task automatic test_skewed();
      logic [3:0] masks [6];
      masks = '{4'b0001, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b1000};
      for (int c = 0; c < 6; c++) begin
         applyStimulus(32'h44332211, masks[c], 1'b1);
         checks++;
         if (c < 5) begin
            if (o_data_val !== 1'b0 || o_data !== 32'h0) begin
               errors++;
               $display("[TB] FAIL skew_wait_c%0d: got val=%b data=%h expected val=0 data=0",
                        c, o_data_val, o_data);
            end
         end else begin
            if (o_data_val !== 1'b1 || o_data !== 32'h44332211) begin
               errors++;
               $display("[TB] FAIL skew_word: got val=%b data=%h expected val=1 data=44332211",
                        o_data_val, o_data);
            end
         end
      end
      applyStimulus(32'h0, 4'h0, 1'b1);
      checks++;
      if (o_data_val !== 1'b0) begin
         errors++;
         $display("[TB] FAIL skew_drained: got val=%b expected 0", o_data_val);
      end
   endtask

   task automatic test_backpressure();
      int exp_cnt;
      for (int n = 1; n <= 10; n++) begin
         applyStimulus(word_of(n - 1), 4'hF, 1'b0);
         exp_cnt = (n > 8) ? 8 : n;
         checks++;
         if (o_lane_count !== {4{4'(exp_cnt)}}) begin
            errors++;
            $display("[TB] FAIL bp_count_push%0d: got %h expected %h",
                     n, o_lane_count, {4{4'(exp_cnt)}});
         end
         checks++;
         if (o_almost_full !== (n >= 6)) begin
            errors++;
            $display("[TB] FAIL bp_almost_full_push%0d: got %b expected %b",
                     n, o_almost_full, (n >= 6));
         end
         checks++;
         if (err_overflow !== 32'((n > 8) ? (n - 8) * 4 : 0)) begin
            errors++;
            $display("[TB] FAIL bp_err_push%0d: got %0d expected %0d",
                     n, err_overflow, (n > 8) ? (n - 8) * 4 : 0);
         end
      end
      // Drain: only the first eight words may come out, in order.
      i_psum_val   = 4'h0;
      i_data_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (o_data_val !== 1'b1 || o_data !== word_of(i)) begin
            errors++;
            $display("[TB] FAIL bp_drain%0d: got val=%b data=%h expected val=1 data=%h",
                     i, o_data_val, o_data, word_of(i));
         end
         step();
      end
      checks++;
      if (o_data_val !== 1'b0 || o_lane_count !== 16'h0) begin
         errors++;
         $display("[TB] FAIL bp_drain_end: got val=%b count=%h expected val=0 count=0000",
                  o_data_val, o_lane_count);
      end
   endtask

   task automatic test_full_push_pop();
      for (int j = 20; j < 28; j++) begin
         applyStimulus(word_of(j), 4'hF, 1'b0);
      end
      checks++;
      if (o_lane_count !== 16'h8888) begin
         errors++;
         $display("[TB] FAIL fpp_filled: got %h expected 8888", o_lane_count);
      end
      // Full lanes, pop of word 20 and push of word 28 on the same edge.
      applyStimulus(word_of(28), 4'hF, 1'b1);
      checks++;
      if (o_lane_count !== 16'h8888) begin
         errors++;
         $display("[TB] FAIL fpp_count: got %h expected 8888", o_lane_count);
      end
      checks++;
      if (err_overflow !== 32'd8) begin
         errors++;
         $display("[TB] FAIL fpp_err: got %0d expected 8", err_overflow);
      end
      i_psum_val = 4'h0;
      for (int j = 21; j <= 28; j++) begin
         checks++;
         if (o_data_val !== 1'b1 || o_data !== word_of(j)) begin
            errors++;
            $display("[TB] FAIL fpp_drain%0d: got val=%b data=%h expected val=1 data=%h",
                     j, o_data_val, o_data, word_of(j));
         end
         step();
      end
      checks++;
      if (o_data_val !== 1'b0) begin
         errors++;
         $display("[TB] FAIL fpp_drain_end: got val=%b expected 0", o_data_val);
      end
   endtask

   task automatic test_reset_mid();
      for (int j = 0; j < 3; j++) begin
         applyStimulus(word_of(50 + j), 4'hF, 1'b0);
      end
      checks++;
      if (o_lane_count !== 16'h3333) begin
         errors++;
         $display("[TB] FAIL rmid_before: got %h expected 3333", o_lane_count);
      end
      // Push and pop offered together with reset must both be ignored.
      rst = 1'b1;
      applyStimulus(32'hDEADBEEF, 4'hF, 1'b1);
      rst = 1'b0;
      i_psum_val   = 4'h0;
      i_data_ready = 1'b0;
      #1;
      checks++;
      if (o_lane_count !== 16'h0 || o_data_val !== 1'b0 || o_data !== 32'h0 ||
          err_overflow !== 32'h0) begin
         errors++;
         $display("[TB] FAIL rmid_cleared: got count=%h val=%b data=%h err=%0d expected all 0",
                  o_lane_count, o_data_val, o_data, err_overflow);
      end
      applyStimulus(32'hA1B2C3D4, 4'hF, 1'b0);
      checks++;
      if (o_data_val !== 1'b1 || o_data !== 32'hA1B2C3D4) begin
         errors++;
         $display("[TB] FAIL rmid_first: got val=%b data=%h expected val=1 data=a1b2c3d4",
                  o_data_val, o_data);
      end
      applyStimulus(32'h0, 4'h0, 1'b1);
      checks++;
      if (o_data_val !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rmid_drained: got val=%b expected 0", o_data_val);
      end
   endtask

   // Scenario sequence; each task leaves the FIFOs empty for the next one.
   initial begin
      checks       = 0;
      errors       = 0;
      rst          = 1'b0;
      i_psum       = '0;
      i_psum_val   = '0;
      i_data_ready = 1'b0;
      #1;
      test_reset();
      test_aligned();
      test_skewed();
      test_backpressure();
      test_full_push_pop();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
